// File: rtl/vdp_sprite_sample_sequencer.sv
// ---------------------------------------------------------------------------
// vdp_sprite_sample_sequencer
//
// Sweeps the active sprite slots of one scan line. For each slot it loads the
// slot parameters (magnification, bit shift, span), then issues one x
// coordinate per cycle to the external divide table. A 3-stage tag pipe
// travels alongside the divide table so each returning sample leaves the
// block tagged with its slot and pixel index.
//
// Optional feature: define VDP_SPRITE_SEQ_ABORT_EN to add an `abort` input.
// abort=1 in LOAD or SWEEP stops issuing and drains the in-flight results.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       synchronous active-low reset
//   start         one-cycle sweep request, accepted only in IDLE
//   sprite_count  number of slots to sweep (0..8, larger values act as 8)
//   abort         (VDP_SPRITE_SEQ_ABORT_EN only) stop the sweep early
//   slot          current slot index for the external parameter lookup
//   param_mgx     magnification of the current slot
//   param_shift   bit shift of the current slot
//   param_len     pixel span of the current slot (0 means 256)
//   hold          stall: no new x is issued this cycle
//   dt_x          divide table x input
//   dt_mgx        divide table reg_mgx input
//   dt_shift      divide table bit_shift input
//   dt_sample_x   divide table result, 3 clk after issue
//   out_valid     result stream valid
//   out_slot      result slot index
//   out_pix       result pixel index within the slot
//   out_sample    result sample (divide table output passed through)
//   busy          sweep in progress (LOAD, SWEEP or DRAIN)
//   done          one-cycle pulse at the end of a sweep
// ---------------------------------------------------------------------------
module vdp_sprite_sample_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] sprite_count,
`ifdef VDP_SPRITE_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic [2:0] slot,
    input  logic [7:0] param_mgx,
    input  logic [1:0] param_shift,
    input  logic [8:0] param_len,
    input  logic       hold,
    output logic [7:0] dt_x,
    output logic [7:0] dt_mgx,
    output logic [1:0] dt_shift,
    input  logic [6:0] dt_sample_x,
    output logic       out_valid,
    output logic [2:0] out_slot,
    output logic [7:0] out_pix,
    output logic [6:0] out_sample,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Registered state
    state_t     state_r;
    logic [2:0] slot_r;
    logic [3:0] count_r;
    logic [8:0] cnt_r;
    logic [8:0] span_r;
    logic [7:0] mgx_r;
    logic [1:0] shift_r;
    logic [7:0] dt_x_r;
    logic [7:0] dt_mgx_r;
    logic [1:0] dt_shift_r;
    logic       done_r;
    logic       busy_r;

    // Tag pipe, stage 1 is written on issue, stage 3 is the output
    logic       s1_valid_r, s2_valid_r, s3_valid_r;
    logic [2:0] s1_slot_r,  s2_slot_r,  s3_slot_r;
    logic [7:0] s1_pix_r,   s2_pix_r,   s3_pix_r;

    // Next-state values
    state_t     state_s;
    logic [2:0] slot_s;
    logic [3:0] count_s;
    logic [8:0] cnt_s;
    logic [8:0] span_s;
    logic [7:0] mgx_s;
    logic [1:0] shift_s;
    logic [7:0] dt_x_s;
    logic [7:0] dt_mgx_s;
    logic [1:0] dt_shift_s;
    logic       done_s;
    logic       push_valid_s;
    logic       abort_s;
    logic       last_pix_s;
    logic       more_slots_s;

`ifdef VDP_SPRITE_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // span_r is never 0 while sweeping, so span_r-1 cannot underflow
    assign last_pix_s   = (cnt_r == (span_r - 9'd1));
    assign more_slots_s = (({1'b0, slot_r} + 4'd1) < count_r);

    // Next-state and next-register computation
    always_comb begin
        state_s      = state_r;
        slot_s       = slot_r;
        count_s      = count_r;
        cnt_s        = cnt_r;
        span_s       = span_r;
        mgx_s        = mgx_r;
        shift_s      = shift_r;
        dt_x_s       = dt_x_r;
        dt_mgx_s     = dt_mgx_r;
        dt_shift_s   = dt_shift_r;
        done_s       = 1'b0;
        push_valid_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (sprite_count == 4'd0) begin
                        done_s = 1'b1;
                    end else begin
                        count_s = (sprite_count > 4'd8) ? 4'd8 : sprite_count;
                        slot_s  = 3'd0;
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (abort_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    mgx_s   = param_mgx;
                    shift_s = param_shift;
                    span_s  = (param_len == 9'd0) ? 9'd256 : param_len;
                    cnt_s   = 9'd0;
                    state_s = ST_SWEEP;
                end
            end

            ST_SWEEP: begin
                if (abort_s) begin
                    state_s = ST_DRAIN;
                end else if (!hold) begin
                    dt_x_s       = cnt_r[7:0];
                    dt_mgx_s     = mgx_r;
                    dt_shift_s   = shift_r;
                    push_valid_s = 1'b1;
                    cnt_s        = cnt_r + 9'd1;
                    if (last_pix_s) begin
                        if (more_slots_s) begin
                            slot_s  = slot_r + 3'd1;
                            state_s = ST_LOAD;
                        end else begin
                            state_s = ST_DRAIN;
                        end
                    end else begin
                        state_s = ST_SWEEP;
                    end
                end else begin
                    state_s = ST_SWEEP;
                end
            end

            ST_DRAIN: begin
                // Once stage 1 is empty nothing valid can enter again, and the
                // entries still in stages 2/3 leave on their own. Finishing
                // here puts done on the same cycle as the last output.
                if (!s1_valid_r) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            slot_r     <= 3'd0;
            count_r    <= 4'd0;
            cnt_r      <= 9'd0;
            span_r     <= 9'd0;
            mgx_r      <= 8'd0;
            shift_r    <= 2'd0;
            dt_x_r     <= 8'd0;
            dt_mgx_r   <= 8'd0;
            dt_shift_r <= 2'd0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            slot_r     <= slot_s;
            count_r    <= count_s;
            cnt_r      <= cnt_s;
            span_r     <= span_s;
            mgx_r      <= mgx_s;
            shift_r    <= shift_s;
            dt_x_r     <= dt_x_s;
            dt_mgx_r   <= dt_mgx_s;
            dt_shift_r <= dt_shift_s;
            done_r     <= done_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    // Tag pipe: advances every cycle, matching the divide table latency
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_slot_r  <= 3'd0;
            s1_pix_r   <= 8'd0;
            s2_valid_r <= 1'b0;
            s2_slot_r  <= 3'd0;
            s2_pix_r   <= 8'd0;
            s3_valid_r <= 1'b0;
            s3_slot_r  <= 3'd0;
            s3_pix_r   <= 8'd0;
        end else begin
            s1_valid_r <= push_valid_s;
            s1_slot_r  <= slot_r;
            s1_pix_r   <= cnt_r[7:0];
            s2_valid_r <= s1_valid_r;
            s2_slot_r  <= s1_slot_r;
            s2_pix_r   <= s1_pix_r;
            s3_valid_r <= s2_valid_r;
            s3_slot_r  <= s2_slot_r;
            s3_pix_r   <= s2_pix_r;
        end
    end

    assign slot       = slot_r;
    assign dt_x       = dt_x_r;
    assign dt_mgx     = dt_mgx_r;
    assign dt_shift   = dt_shift_r;
    assign out_valid  = s3_valid_r;
    assign out_slot   = s3_slot_r;
    assign out_pix    = s3_pix_r;
    assign out_sample = dt_sample_x;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_vdp_sprite_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vdp_sprite_sample_sequencer
//
// Directed bench. Slot parameters come from small tables indexed by the DUT
// slot output; the divide table is modelled as a 2-register pipe behind
// dt_x/dt_mgx/dt_shift so its result arrives 3 clk after the issue cycle.
// Cycle k of a run is the cycle after the k-th rising edge following the
// cycle in which start was driven high.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vdp_sprite_sample_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] sprite_count;
    logic       abort;
    logic [2:0] slot;
    logic [7:0] param_mgx;
    logic [1:0] param_shift;
    logic [8:0] param_len;
    logic       hold;
    logic [7:0] dt_x;
    logic [7:0] dt_mgx;
    logic [1:0] dt_shift;
    logic [6:0] dt_sample_x;
    logic       out_valid;
    logic [2:0] out_slot;
    logic [7:0] out_pix;
    logic [6:0] out_sample;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    vdp_sprite_sample_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .sprite_count (sprite_count),
`ifdef VDP_SPRITE_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .slot         (slot),
        .param_mgx    (param_mgx),
        .param_shift  (param_shift),
        .param_len    (param_len),
        .hold         (hold),
        .dt_x         (dt_x),
        .dt_mgx       (dt_mgx),
        .dt_shift     (dt_shift),
        .dt_sample_x  (dt_sample_x),
        .out_valid    (out_valid),
        .out_slot     (out_slot),
        .out_pix      (out_pix),
        .out_sample   (out_sample),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot parameter tables
    logic [7:0] p_mgx   [0:7];
    logic [1:0] p_shift [0:7];
    logic [8:0] p_len   [0:7];

    always_comb begin
        param_mgx   = p_mgx[slot];
        param_shift = p_shift[slot];
        param_len   = p_len[slot];
    end

    function automatic logic [6:0] f_div(input logic [7:0] x, input logic [7:0] m,
                                         input logic [1:0] s);
        logic [8:0] t;
        t = ({1'b0, x} + {1'b0, m}) >> s;
        return t[6:0];
    endfunction

    // Divide table model
    logic [6:0] dt_d1, dt_d2;
    always @(posedge clk) begin
        dt_d1 <= f_div(dt_x, dt_mgx, dt_shift);
        dt_d2 <= dt_d1;
    end
    assign dt_sample_x = dt_d2;

    // Per-cycle log of a run
    localparam int NLOG = 300;
    logic       log_valid  [0:NLOG-1];
    logic [2:0] log_slot   [0:NLOG-1];
    logic [7:0] log_pix    [0:NLOG-1];
    logic [6:0] log_sample [0:NLOG-1];
    logic       log_done   [0:NLOG-1];
    logic       log_busy   [0:NLOG-1];
    logic [7:0] log_dtx    [0:NLOG-1];
    logic [7:0] log_dtmgx  [0:NLOG-1];
    logic [2:0] log_cur    [0:NLOG-1];

    // Run knobs (cycle indices, -1 = unused)
    int hold_from, hold_len, restart_k, abort_k, rst_k;

    task automatic clear_knobs();
        hold_from = -1; hold_len = 0; restart_k = -1; abort_k = -1; rst_k = -1;
    endtask

    // Drives start and records ncyc cycles
    task automatic run(input int ncyc, input logic [3:0] cnt);
        for (int i = 0; i < NLOG; i++) begin
            log_valid[i] = 1'b0; log_slot[i] = 3'd0; log_pix[i] = 8'd0;
            log_sample[i] = 7'd0; log_done[i] = 1'b0; log_busy[i] = 1'b0;
            log_dtx[i] = 8'd0; log_dtmgx[i] = 8'd0; log_cur[i] = 3'd0;
        end
        start = 1'b1;
        sprite_count = cnt;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            log_valid[k]  = out_valid;
            log_slot[k]   = out_slot;
            log_pix[k]    = out_pix;
            log_sample[k] = out_sample;
            log_done[k]   = done;
            log_busy[k]   = busy;
            log_dtx[k]    = dt_x;
            log_dtmgx[k]  = dt_mgx;
            log_cur[k]    = slot;
            start   = (k == restart_k);
            hold    = (k >= hold_from) && (k < hold_from + hold_len);
            abort   = (k == abort_k);
            reset_n = (k != rst_k);
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0; reset_n = 1'b1;
        clear_knobs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(3);
        checks++; if (slot !== 3'd0)     begin errors++; $display("FAIL reset_slot got %0d want 0", slot); end
        checks++; if (dt_x !== 8'd0)     begin errors++; $display("FAIL reset_dt_x got %0d want 0", dt_x); end
        checks++; if (dt_mgx !== 8'd0)   begin errors++; $display("FAIL reset_dt_mgx got %0d want 0", dt_mgx); end
        checks++; if (dt_shift !== 2'd0) begin errors++; $display("FAIL reset_dt_shift got %0d want 0", dt_shift); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_slot !== 3'd0) begin errors++; $display("FAIL reset_out_slot got %0d want 0", out_slot); end
        checks++; if (out_pix !== 8'd0)  begin errors++; $display("FAIL reset_out_pix got %0d want 0", out_pix); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
        reset_n = 1'b1;
        idle(2);
    endtask

    // One slot, len 20, with an ignored start pulse in the middle
    task automatic test_single();
        p_mgx[0] = 8'd16; p_shift[0] = 2'd0; p_len[0] = 9'd20;
        restart_k = 8;
        run(30, 4'd1);
        checks++; if (log_valid[4] !== 1'b0) begin errors++; $display("FAIL single_pre_valid got %b want 0", log_valid[4]); end
        for (int k = 5; k <= 24; k++) begin
            checks++;
            if (log_valid[k] !== 1'b1 || log_slot[k] !== 3'd0 || log_pix[k] !== 8'(k - 5) ||
                log_sample[k] !== f_div(8'(k - 5), 8'd16, 2'd0)) begin
                errors++;
                $display("FAIL single_out k=%0d got v=%b s=%0d p=%0d x=%0d want v=1 s=0 p=%0d x=%0d",
                         k, log_valid[k], log_slot[k], log_pix[k], log_sample[k], k - 5,
                         f_div(8'(k - 5), 8'd16, 2'd0));
            end
        end
        for (int k = 1; k <= 30; k++) begin
            checks++;
            if (log_done[k] !== (k == 24)) begin
                errors++; $display("FAIL single_done k=%0d got %b want %b", k, log_done[k], (k == 24));
            end
        end
        checks++; if (log_valid[25] !== 1'b0) begin errors++; $display("FAIL single_post_valid got %b want 0", log_valid[25]); end
        checks++; if (log_busy[10] !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", log_busy[10]); end
        checks++; if (log_busy[25] !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", log_busy[25]); end
        checks++; if (log_dtmgx[5] !== 8'd16) begin errors++; $display("FAIL single_dt_mgx got %0d want 16", log_dtmgx[5]); end
        idle(2);
    endtask

    // Two slots: len 4 then len 3 with mgx 19
    task automatic test_multi();
        p_mgx[0] = 8'd16; p_shift[0] = 2'd1; p_len[0] = 9'd4;
        p_mgx[1] = 8'd19; p_shift[1] = 2'd2; p_len[1] = 9'd3;
        run(16, 4'd2);
        for (int k = 5; k <= 8; k++) begin
            checks++;
            if (log_valid[k] !== 1'b1 || log_slot[k] !== 3'd0 || log_pix[k] !== 8'(k - 5) ||
                log_sample[k] !== f_div(8'(k - 5), 8'd16, 2'd1)) begin
                errors++;
                $display("FAIL multi_s0 k=%0d got v=%b s=%0d p=%0d x=%0d want v=1 s=0 p=%0d",
                         k, log_valid[k], log_slot[k], log_pix[k], log_sample[k], k - 5);
            end
        end
        checks++; if (log_valid[9] !== 1'b0) begin errors++; $display("FAIL multi_gap got %b want 0", log_valid[9]); end
        for (int k = 10; k <= 12; k++) begin
            checks++;
            if (log_valid[k] !== 1'b1 || log_slot[k] !== 3'd1 || log_pix[k] !== 8'(k - 10) ||
                log_sample[k] !== f_div(8'(k - 10), 8'd19, 2'd2)) begin
                errors++;
                $display("FAIL multi_s1 k=%0d got v=%b s=%0d p=%0d x=%0d want v=1 s=1 p=%0d",
                         k, log_valid[k], log_slot[k], log_pix[k], log_sample[k], k - 10);
            end
        end
        checks++; if (log_dtmgx[7] !== 8'd16) begin errors++; $display("FAIL multi_mgx_before got %0d want 16", log_dtmgx[7]); end
        checks++; if (log_dtmgx[8] !== 8'd19) begin errors++; $display("FAIL multi_mgx_after got %0d want 19", log_dtmgx[8]); end
        checks++; if (log_cur[6] !== 3'd1) begin errors++; $display("FAIL multi_slot got %0d want 1", log_cur[6]); end
        checks++; if (log_done[12] !== 1'b1 || log_done[11] !== 1'b0 || log_done[13] !== 1'b0) begin
            errors++; $display("FAIL multi_done got %b%b%b want 010", log_done[11], log_done[12], log_done[13]);
        end
        checks++; if (log_valid[13] !== 1'b0) begin errors++; $display("FAIL multi_post_valid got %b want 0", log_valid[13]); end
        idle(2);
    endtask

    // len 0 means a 256-pixel span
    task automatic test_len256();
        int ndone;
        logic slot_ok;
        p_mgx[0] = 8'd0; p_shift[0] = 2'd3; p_len[0] = 9'd0;
        run(266, 4'd1);
        ndone = 0;
        slot_ok = 1'b1;
        for (int k = 5; k <= 260; k++) begin
            checks++;
            if (log_valid[k] !== 1'b1 || log_slot[k] !== 3'd0 || log_pix[k] !== 8'(k - 5) ||
                log_sample[k] !== f_div(8'(k - 5), 8'd0, 2'd3)) begin
                errors++;
                $display("FAIL len256_out k=%0d got v=%b s=%0d p=%0d x=%0d want p=%0d",
                         k, log_valid[k], log_slot[k], log_pix[k], log_sample[k], k - 5);
            end
        end
        for (int k = 1; k <= 266; k++) begin
            if (log_done[k] === 1'b1) ndone++;
            if (log_cur[k] !== 3'd0) slot_ok = 1'b0;
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL len256_ndone got %0d want 1", ndone); end
        checks++; if (log_done[260] !== 1'b1) begin errors++; $display("FAIL len256_done got %b want 1", log_done[260]); end
        checks++; if (slot_ok !== 1'b1) begin errors++; $display("FAIL len256_slot got moved want 0"); end
        checks++; if (log_valid[261] !== 1'b0) begin errors++; $display("FAIL len256_post got %b want 0", log_valid[261]); end
        idle(2);
    endtask

    // hold for 5 cycles while pixel 8 is next
    task automatic test_hold();
        int n;
        int gaps;
        p_mgx[0] = 8'd40; p_shift[0] = 2'd1; p_len[0] = 9'd20;
        hold_from = 10; hold_len = 5;
        run(34, 4'd1);
        for (int k = 10; k <= 15; k++) begin
            checks++;
            if (log_dtx[k] !== 8'd7) begin errors++; $display("FAIL hold_dt_x k=%0d got %0d want 7", k, log_dtx[k]); end
        end
        n = 0; gaps = 0;
        for (int k = 5; k <= 29; k++) begin
            if (log_valid[k] === 1'b1) begin
                checks++;
                if (log_pix[k] !== 8'(n) || log_sample[k] !== f_div(8'(n), 8'd40, 2'd1)) begin
                    errors++; $display("FAIL hold_order k=%0d got p=%0d x=%0d want p=%0d", k, log_pix[k], log_sample[k], n);
                end
                n++;
            end else begin
                gaps++;
            end
        end
        checks++; if (n !== 20) begin errors++; $display("FAIL hold_count got %0d want 20", n); end
        checks++; if (gaps !== 5) begin errors++; $display("FAIL hold_gaps got %0d want 5", gaps); end
        checks++; if (log_done[29] !== 1'b1 || log_done[28] !== 1'b0) begin
            errors++; $display("FAIL hold_done got %b%b want 01", log_done[28], log_done[29]);
        end
        idle(2);
    endtask

    // reset while pixel 10 is issued, then a zero-count start
    task automatic test_reset_mid();
        logic quiet;
        p_mgx[0] = 8'd5; p_shift[0] = 2'd0; p_len[0] = 9'd20;
        rst_k = 12;
        run(40, 4'd1);
        checks++;
        if (log_valid[13] !== 1'b0 || log_slot[13] !== 3'd0 || log_pix[13] !== 8'd0 ||
            log_dtx[13] !== 8'd0 || log_busy[13] !== 1'b0 || log_cur[13] !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_zero got v=%b s=%0d p=%0d x=%0d b=%b sl=%0d want all 0",
                     log_valid[13], log_slot[13], log_pix[13], log_dtx[13], log_busy[13], log_cur[13]);
        end
        quiet = 1'b1;
        for (int k = 13; k <= 40; k++) begin
            if (log_valid[k] !== 1'b0 || log_done[k] !== 1'b0 || log_busy[k] !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rstmid_quiet got activity want none"); end
        run(4, 4'd0);
        checks++; if (log_done[1] !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", log_done[1]); end
        checks++; if (log_done[2] !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b want 0", log_done[2]); end
        checks++; if (log_busy[1] !== 1'b0 || log_busy[2] !== 1'b0) begin
            errors++; $display("FAIL zero_busy got %b%b want 00", log_busy[1], log_busy[2]);
        end
        idle(2);
    endtask

`ifdef VDP_SPRITE_SEQ_ABORT_EN
    // abort in the cycle pixel 7 would issue
    task automatic test_abort();
        p_mgx[0] = 8'd16; p_shift[0] = 2'd0; p_len[0] = 9'd20;
        abort_k = 9;
        run(20, 4'd1);
        for (int k = 5; k <= 11; k++) begin
            checks++;
            if (log_valid[k] !== 1'b1 || log_pix[k] !== 8'(k - 5)) begin
                errors++; $display("FAIL abort_out k=%0d got v=%b p=%0d want v=1 p=%0d", k, log_valid[k], log_pix[k], k - 5);
            end
        end
        checks++; if (log_valid[12] !== 1'b0) begin errors++; $display("FAIL abort_post got %b want 0", log_valid[12]); end
        checks++; if (log_done[11] !== 1'b1 || log_done[12] !== 1'b0) begin
            errors++; $display("FAIL abort_done got %b%b want 10", log_done[11], log_done[12]);
        end
        checks++; if (log_busy[11] !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", log_busy[11]); end
        idle(2);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start = 1'b0;
        sprite_count = 4'd0;
        abort = 1'b0;
        hold = 1'b0;
        clear_knobs();
        for (int i = 0; i < 8; i++) begin
            p_mgx[i] = 8'd0; p_shift[i] = 2'd0; p_len[i] = 9'd1;
        end
        test_reset();
        test_single();
        test_multi();
        test_len256();
        test_hold();
        test_reset_mid();
`ifdef VDP_SPRITE_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdp_sprite_sample_sequencer.md
VDP_SPRITE_SAMPLE_SEQUENCER -- requirements
Module: vdp_sprite_sample_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port start  input  1  one-cycle pulse that begins a line sweep; ignored unless IDLE.
REQ-004 SHALL have port sprite_count  input  4  number of slots to sweep, 0..8 (values >8 treated as 8); sampled on accepted start.
REQ-005 SHALL have port slot  output  3  current slot index, drives external parameter lookup.
REQ-006 SHALL have ports param_mgx  input  8, param_shift  input  2, param_len  input  9  slot parameters, valid combinationally for current slot; param_len 0 means 256.
REQ-007 SHALL have port hold  input  1  when 1, no new x is issued that cycle.
REQ-008 SHALL have ports dt_x  output  8, dt_mgx  output  8, dt_shift  output  2  drive vdp_sprite_divide_table x, reg_mgx, bit_shift.
REQ-009 SHALL have port dt_sample_x  input  7  divide table result, 3 clk after issue.
REQ-010 SHALL have ports out_valid  output  1, out_slot  output  3, out_pix  output  8, out_sample  output  7  aligned result stream.
REQ-011 SHALL have ports busy  output  1 and done  output  1 (one-cycle pulse at sweep end).

Function
REQ-012 SHALL implement states IDLE, LOAD, SWEEP, DRAIN.
REQ-013 IDLE->LOAD on start when sprite_count>0; start with sprite_count=0 SHALL pulse done next cycle and stay IDLE.
REQ-014 LOAD SHALL latch param_mgx/param_shift and span = (param_len==0 ? 256 : param_len) for current slot, clear pixel counter, go to SWEEP next cycle.
REQ-015 SWEEP, hold=0: SHALL drive dt_x = pixel counter, dt_mgx/dt_shift = latched values, push tag {slot, pix} with valid=1 into 3-stage tag pipe, increment counter.
REQ-016 SWEEP, hold=1: SHALL keep dt_x/dt_mgx/dt_shift unchanged, push valid=0 tag, not increment.
REQ-017 After issuing pixel span-1: if slot+1 < count, SHALL increment slot and go to LOAD; else go to DRAIN.
REQ-018 Tag pipe SHALL advance every cycle regardless of state or hold; out_valid/out_slot/out_pix SHALL be stage-3 tag, out_sample = dt_sample_x same cycle (issue-to-output latency exactly 3 clk).
REQ-019 DRAIN SHALL wait until tag pipe holds no valid entry, then pulse done and return to IDLE (done asserted exactly 3 clk after last issue).
REQ-020 busy SHALL be 1 in LOAD, SWEEP, DRAIN; 0 in IDLE.
REQ-021 Pixel counter SHALL be 9 bits; dt_x = low 8 bits; span 256 issues x=0..255 without wrap into next slot.
REQ-022 start while busy SHALL be ignored with no effect on sweep.
REQ-023 One LOAD bubble cycle per slot SHALL be inserted (no issue in LOAD; valid=0 tag pushed).

Reset
REQ-024 reset_n=0 at clk edge SHALL force IDLE, slot=0, counter=0, dt_x=0, dt_mgx=0, dt_shift=0, all tag valids=0, out_valid=0, out_slot=0, out_pix=0, busy=0, done=0.
REQ-025 Reset mid-sweep SHALL discard all in-flight tags; no out_valid or done after release until new start.

Configuration
REQ-026 Macro VDP_SPRITE_SEQ_ABORT_EN: when defined, SHALL add input abort (1 bit); abort=1 in LOAD/SWEEP SHALL stop issuing and enter DRAIN (in-flight results still delivered, then done); abort in IDLE/DRAIN ignored.
REQ-027 Without VDP_SPRITE_SEQ_ABORT_EN, no abort port SHALL exist and sweeps always run to completion.

Verification
REQ-028 start, count=1, mgx=16, shift=0, len=20, hold=0 -> out_pix 0..19 on 20 consecutive cycles, first out_valid 5 clk after start (LOAD+issue+3), done 3 clk after last issue.
REQ-029 count=2, slot0 len=4, slot1 len=3 mgx=19 -> out_slot 0 x4, one invalid gap, out_slot 1 x3; dt_mgx switches to 19 at slot1 first issue.
REQ-030 len=0, mgx=0, shift=3 -> 256 outputs, out_pix 0..255, slot never increments past 0, single done.
REQ-031 hold=1 for 5 cycles mid-sweep len=20 -> dt_x frozen, 5 invalid output cycles, all 20 pixels delivered once in order.
REQ-032 reset_n=0 at pixel 10 of len=20 -> outputs zero, out_valid never asserted after release, busy=0; start with count=0 -> done pulse next cycle, busy stays 0.
REQ-033 With VDP_SPRITE_SEQ_ABORT_EN, abort at pixel 7 of len=20 -> pixels 0..6 (plus any issued same-cycle) output, done 3 clk after last issue, IDLE.
